// File: rtl/uart_block_client.sv
// Initiator for the 8-byte UART block exchange: sends a 64-bit request MSB-first,
// then reassembles an 8-byte reply (first byte lands in [7:0]) or gives up on a timeout.
module uart_block_client #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_data,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RX} state_e;

  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [63:0] tx_shift_q, tx_shift_d;
  logic [2:0]  tx_cnt_q, tx_cnt_d;
  logic [63:0] rx_shift_q, rx_shift_d;
  logic [2:0]  rx_cnt_q, rx_cnt_d;
  logic [23:0] to_cnt_q, to_cnt_d;
  logic        rx_prev_q, rx_prev_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        timeout_q, timeout_d;
  logic        rx_rise;

  assign rx_rise = rx_valid & ~rx_prev_q;

  always_comb begin
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    tx_cnt_d    = tx_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_cnt_d    = rx_cnt_q;
    to_cnt_d    = to_cnt_q;
    rx_prev_d   = rx_valid;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          tx_shift_d = req_data;
          tx_cnt_d   = 3'd0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_shift_d = {tx_shift_q[55:0], 8'h00};
          tx_cnt_d   = tx_cnt_q + 3'd1;
          if (tx_cnt_q == 3'd7) begin
            rx_cnt_d = 3'd0;
            to_cnt_d = 24'd0;
            state_d  = WAIT_RX;
          end
        end
      end
      WAIT_RX: begin
        // A capture beats the timeout when both land in the same cycle.
        if (rx_rise) begin
          rx_shift_d = {rx_byte, rx_shift_q[63:8]};
          rx_cnt_d   = rx_cnt_q + 3'd1;
          to_cnt_d   = 24'd0;
          if (rx_cnt_q == 3'd7) begin
            rsp_data_d  = {rx_byte, rx_shift_q[63:8]};
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_shift_q  <= '0;
      tx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      rx_cnt_q    <= '0;
      to_cnt_q    <= '0;
      rx_prev_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_cnt_q    <= rx_cnt_d;
      to_cnt_q    <= to_cnt_d;
      rx_prev_q   <= rx_prev_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign tx_valid  = (state_q == SEND);
  assign tx_byte   = tx_valid ? tx_shift_q[63:56] : 8'h00;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/uart_block_client.md
# uart_block_client

Initiator side of the 8-byte UART block exchange. The block takes one 64-bit request word, serializes it MSB-first into a byte-wide UART transmitter, then collects the 8-byte reply LSB-first from a byte-wide UART receiver. It presents the reassembled 64-bit response, or flags a timeout. It sits between a test or host-side sequencer and the uart_tx/uart_rx byte engines, and drives the block-cipher responder at the far end of the serial link.

## Interface
- TIMEOUT_CYCLES, default 10_000_000: maximum idle cycles between reply bytes while waiting; range 2..2^24-1.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request word available.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_data  in  64  request word; sampled on the accept cycle.
- tx_byte  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_byte is valid.
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready.
- rx_byte  in  8  byte from the UART receiver.
- rx_valid  in  1  receiver data-valid level; one byte per rising edge.
- rsp_valid  out  1  one-cycle pulse; rsp_data holds a complete reply.
- rsp_data  out  64  last complete reply; holds until the next completion.
- timeout  out  1  one-cycle pulse; the reply was abandoned.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SEND, WAIT_RX.
- IDLE
  - req_ready=1.
  - On req_valid: latch req_data into the tx shift register, clear tx_cnt, go to SEND.
- SEND
  - tx_valid=1; tx_byte = shift[63:56].
  - On tx_valid && tx_ready: shift left 8 and increment tx_cnt.
  - When the 8th byte is accepted (tx_cnt==7): clear rx_cnt and the timeout counter, go to WAIT_RX.
- WAIT_RX
  - A byte is captured when rx_valid is high and was low in the previous cycle. The edge detector register runs in all states and resets to 0.
  - Capture: rx_shift <= {rx_byte, rx_shift[63:8]}. The first received byte ends up in bits [7:0].
  - Each capture increments rx_cnt and clears the timeout counter.
  - 8th capture: rsp_data <= {rx_byte, rx_shift[63:8]}, pulse rsp_valid, go to IDLE.
  - Otherwise the timeout counter increments every cycle. When it reaches TIMEOUT_CYCLES-1 with no capture: pulse timeout, go to IDLE. rsp_data is unchanged.
- Outside WAIT_RX, rx edges are ignored; stray bytes are dropped.
- Reset value of every output is 0: req_ready=0 during reset, 1 from the first cycle after rst deasserts. All counters and shift registers also reset to 0.
- rst at any point, including mid-SEND or mid-WAIT_RX, aborts immediately. No rsp_valid or timeout pulse is produced, and tx_valid drops in the cycle after rst is sampled.

## Timing
- Request accepted at cycle T (req_valid && req_ready): tx_valid=1 with the first byte at T+1.
- Byte k accepted at cycle A: byte k+1 is presented at A+1. Zero-bubble streaming when tx_ready is held high, so 8 bytes occupy T+1..T+8.
- tx_ready low: tx_byte and tx_valid hold stable; no byte skipped or repeated.
- Last byte accepted at A: WAIT_RX at A+1. An rx edge at A+1 is captured.
- 8th rx edge sampled at cycle R: rsp_valid=1 and rsp_data updated at R+1, with state IDLE and req_ready=1 in the same cycle.
- A new request may be accepted in the same cycle as rsp_valid or timeout.
- rx_valid held high for many cycles counts as one byte. An edge and the timeout limit in the same cycle: the edge wins and the counter clears.
- Timeout: the pulse fires TIMEOUT_CYCLES cycles after WAIT_RX entry or after the last capture.

## Test plan
- req_data=64'h0123456789ABCDEF with tx_ready tied high -> tx_byte sequence 01,23,45,67,89,AB,CD,EF on 8 consecutive cycles starting T+1; reply bytes 11,22,33,44,55,66,77,88 -> rsp_valid one cycle with rsp_data=64'h8877665544332211.
- Backpressure: tx_ready toggles 1-0-0-1 pseudo-randomly -> exactly 8 accepted bytes in MSB-first order; tx_byte is stable while tx_ready=0.
- TIMEOUT_CYCLES=100: send the request, then 3 reply bytes, then silence -> timeout pulses exactly 100 cycles after the 3rd capture; rsp_valid never fires; rsp_data keeps its prior value; req_ready=1 the same cycle.
- rx_valid held high for 5 cycles per byte and bytes arriving during SEND -> SEND-phase bytes are discarded; each held pulse counts once; the response is correct.
- rst asserted after 4 tx bytes, then a new request 64'hCAB00D1E -> all outputs 0 after the reset cycle; the next transfer starts cleanly with bytes 00,00,00,00,CA,B0,0D,1E.
- Back-to-back: a second request is offered in the rsp_valid cycle -> it is accepted that cycle and its first byte appears the next cycle.
